// File: rtl/sram_model_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_model_pkg
//  Description : Shared definitions for the clock-sampled asynchronous SRAM
//                model: FSM state encoding, sticky error bit positions,
//                access counter width and a width helper for the cycle timers.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_model_pkg;

    // Bus-cycle tracking states
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,   // clear sequencer walking the array
        ST_IDLE  = 2'd1,   // chip deselected
        ST_READ  = 2'd2,   // read strobe active
        ST_WRITE = 2'd3    // write strobe active
    } state_t;

    // Sticky error bit positions
    localparam int c_err_short_wr = 0;   // write strobe shorter than TWP
    localparam int c_err_addr_chg = 1;   // address moved during a write strobe
    localparam int c_err_busy     = 2;   // access attempted while clearing
    localparam int c_err_range    = 3;   // address beyond DEPTH
    localparam int c_err_w        = 4;

    // Access counter width
    localparam int c_cnt_w = 32;

    // Bits needed to hold 0..max (at least one bit)
    function automatic int unsigned timer_width(input int unsigned max);
        return (max > 0) ? $clog2(max + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_model_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sram_model_timer
//  Description : Saturating cycle counter. 'clear' forces zero, 'restart'
//                loads one (the cycle that starts the measurement counts),
//                'en' advances until the count reaches MAX. 'sat' is high
//                while the count equals MAX.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                clear        - force count to zero
//                restart      - begin a new measurement at one
//                en           - count this cycle
//                sat          - count has reached MAX
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_model_timer #(
    parameter int unsigned MAX = 2,
    parameter int unsigned W   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic restart,
    input  logic en,
    output logic sat
);

    localparam logic [W-1:0] c_max   = W'(MAX);
    localparam logic [W-1:0] c_first = (MAX >= 1) ? W'(1) : '0;

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (restart) begin
            r_count <= c_first;
        end else if (en && (r_count != c_max)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign sat = (r_count == c_max);

endmodule
`default_nettype wire

// File: rtl/sram_model_p.sv
`default_nettype none
// ============================================================================
//  Module      : sram_model_p
//  Description : Parametrised, clock-sampled behavioural model of an
//                asynchronous SRAM. Samples the bus on every clk rising edge
//                (clk must run well above the bus-cycle rate). Emulates read
//                access time, commits writes on the trailing edge of the
//                strobe, checks strobe width and address stability, supports
//                a write-protect window, a watch-address trap, access counters
//                and an optional clear-on-reset sequencer.
//  Ports       : clk        - sample clock
//                rst        - synchronous active-high reset
//                addr       - SRAM address
//                data       - bidirectional data bus
//                ceb/rnw/oeb- chip enable (low), read-not-write, output enable (low)
//                wp_en      - enables the write-protect window
//                busy       - clear sequencer running
//                watch_hit  - sticky, committed write to WATCH_ADDR
//                err        - sticky errors: [0] short write, [1] addr change
//                             during write, [2] access while busy,
//                             [3] out-of-range address
//                rd_count   - completed read cycles
//                wr_count   - committed writes
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_model_p
    import sram_model_pkg::*;
#(
    parameter int unsigned   DW             = 8,
    parameter int unsigned   AW             = 19,
    parameter int unsigned   DEPTH          = 1 << AW,
    parameter int unsigned   TACC           = 2,
    parameter int unsigned   TWP            = 2,
    parameter bit            CLEAR_ON_RESET = 1'b1,
    parameter logic [AW-1:0] WATCH_ADDR     = 'h70000,
    parameter logic [AW-1:0] WP_LO          = 'h0,
    parameter logic [AW-1:0] WP_HI          = 'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       addr,
    inout  logic [DW-1:0]       data,
    input  logic                ceb,
    input  logic                rnw,
    input  logic                oeb,
    input  logic                wp_en,
    output logic                busy,
    output logic                watch_hit,
    output logic [c_err_w-1:0]  err,
    output logic [c_cnt_w-1:0]  rd_count,
    output logic [c_cnt_w-1:0]  wr_count
);

    localparam int unsigned        c_idx_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_idx_w-1:0] c_last_ptr  = c_idx_w'(DEPTH - 1);
    localparam logic [AW:0]        c_depth_ext = (AW + 1)'(DEPTH);
    localparam int unsigned        c_tacc_w    = timer_width(TACC);
    localparam int unsigned        c_twp_w     = timer_width(TWP);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_next_state;

    logic [DW-1:0]        r_mem [DEPTH];
    logic [c_idx_w-1:0]   r_clr_ptr;
    logic [AW-1:0]        r_addr_q;      // address seen on the previous edge
    logic [AW-1:0]        r_waddr;       // address latched at write entry
    logic [DW-1:0]        r_wdata;       // last data sampled under the strobe
    logic                 r_poison;
    logic [c_err_w-1:0]   r_err;
    logic                 r_watch_hit;
    logic [c_cnt_w-1:0]   r_rd_count;
    logic [c_cnt_w-1:0]   r_wr_count;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic w_strobe_rd;
    logic w_strobe_wr;
    logic w_addr_oor;
    logic w_waddr_oor;
    logic w_wp_hit;

    assign w_strobe_rd = !ceb && rnw;
    assign w_strobe_wr = !ceb && !rnw;
    assign w_addr_oor  = ({1'b0, addr}    >= c_depth_ext);
    assign w_waddr_oor = ({1'b0, r_waddr} >= c_depth_ext);
    // A leading one on both sides keeps the lower-bound test well formed
    // even when the window starts at address zero.
    assign w_wp_hit    = wp_en
                         && ({1'b1, r_waddr} >= {1'b1, WP_LO})
                         && (r_waddr <= WP_HI);

    // ------------------------------------------------------------------
    // Cycle events
    // ------------------------------------------------------------------
    logic w_in_clear;
    logic w_wr_entry;
    logic w_wr_cont;
    logic w_wr_exit;
    logic w_rd_entry;
    logic w_rd_exit;
    logic w_rd_clear;
    logic w_addr_moved;
    logic w_rd_sat;
    logic w_wr_sat;
    logic w_commit;

    assign w_in_clear   = (r_state == ST_CLEAR);
    assign w_wr_entry   = ((r_state == ST_IDLE) || (r_state == ST_READ)) && w_strobe_wr;
    assign w_wr_cont    = (r_state == ST_WRITE) && w_strobe_wr;
    assign w_wr_exit    = (r_state == ST_WRITE) && !w_strobe_wr;
    assign w_rd_entry   = ((r_state == ST_IDLE) || (r_state == ST_WRITE)) && w_strobe_rd;
    assign w_rd_exit    = (r_state == ST_READ) && !w_strobe_rd;
    // Access time restarts on entry and whenever the address moves
    assign w_rd_clear   = w_rd_entry || ((r_state == ST_READ) && (addr != r_addr_q));
    assign w_addr_moved = w_wr_cont && (addr != r_waddr);
    assign w_commit     = w_wr_exit && w_wr_sat && !r_poison && !w_waddr_oor && !w_wp_hit;

    sram_model_timer #(
        .MAX     (TACC),
        .W       (c_tacc_w)
    ) u_rd_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_rd_clear),
        .restart (1'b0),
        .en      ((r_state == ST_READ) && w_strobe_rd),
        .sat     (w_rd_sat)
    );

    sram_model_timer #(
        .MAX     (TWP),
        .W       (c_twp_w)
    ) u_wr_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_in_clear),
        .restart (w_wr_entry),
        .en      (w_wr_cont),
        .sat     (w_wr_sat)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_CLEAR: begin
                if (r_clr_ptr == c_last_ptr) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!ceb) begin
                    w_next_state = rnw ? ST_READ : ST_WRITE;
                end
            end
            ST_READ: begin
                if (ceb) begin
                    w_next_state = ST_IDLE;
                end else if (!rnw) begin
                    w_next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (ceb) begin
                    w_next_state = ST_IDLE;
                end else if (rnw) begin
                    w_next_state = ST_READ;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Write tracking, errors and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_ptr   <= '0;
            r_addr_q    <= '0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_poison    <= 1'b0;
            r_err       <= '0;
            r_watch_hit <= 1'b0;
            r_rd_count  <= '0;
            r_wr_count  <= '0;
        end else begin
            r_addr_q <= addr;

            if (w_in_clear) begin
                r_clr_ptr <= r_clr_ptr + c_idx_w'(1);
                // The access is ignored; only the error is recorded
                if (!ceb) begin
                    r_err[c_err_busy] <= 1'b1;
                end
            end else if (!ceb && w_addr_oor) begin
                r_err[c_err_range] <= 1'b1;
            end

            if (w_wr_entry) begin
                r_waddr  <= addr;
                r_poison <= 1'b0;
            end

            if (w_wr_entry || w_wr_cont) begin
                r_wdata <= data;
            end

            if (w_addr_moved) begin
                r_poison               <= 1'b1;
                r_err[c_err_addr_chg]  <= 1'b1;
            end

            if (w_wr_exit && !w_wr_sat) begin
                r_err[c_err_short_wr] <= 1'b1;
            end

            if (w_commit) begin
                r_wr_count <= r_wr_count + c_cnt_w'(1);
                if (r_waddr == WATCH_ADDR) begin
                    r_watch_hit <= 1'b1;
                end
            end

            if (w_rd_exit) begin
                r_rd_count <= r_rd_count + c_cnt_w'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory array: single write port shared by clear walk and commit
    // ------------------------------------------------------------------
    logic                w_mem_we;
    logic [c_idx_w-1:0]  w_mem_idx;
    logic [DW-1:0]       w_mem_wdata;

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_idx   = r_clr_ptr;
        w_mem_wdata = '0;
        if (!rst) begin
            if (w_in_clear) begin
                w_mem_we = 1'b1;
            end else if (w_commit) begin
                w_mem_we    = 1'b1;
                w_mem_idx   = r_waddr[c_idx_w-1:0];
                w_mem_wdata = r_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read data drive: X until the access time has elapsed at a stable
    // in-range address
    // ------------------------------------------------------------------
    logic          w_drive;
    logic [DW-1:0] w_rd_data;

    assign w_drive   = (r_state == ST_READ) && w_strobe_rd && !oeb;
    assign w_rd_data = (w_rd_sat && !w_addr_oor) ? r_mem[addr[c_idx_w-1:0]] : {DW{1'bx}};
    assign data      = w_drive ? w_rd_data : {DW{1'bz}};

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy      = w_in_clear;
    assign watch_hit = r_watch_hit;
    assign err       = r_err;
    assign rd_count  = r_rd_count;
    assign wr_count  = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_sram_model_p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_model_p
//  Description : Directed self-checking bench for sram_model_p with a 16-word
//                array. Expected read data is queued when a read is issued and
//                compared when the model drives the bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_model_p;

    localparam int unsigned   DW    = 8;
    localparam int unsigned   AW    = 5;
    localparam int unsigned   DEPTH = 16;
    localparam int unsigned   TACC  = 2;
    localparam int unsigned   TWP   = 2;
    localparam logic [AW-1:0] WATCH = 5'h02;
    localparam logic [AW-1:0] WPLO  = 5'h08;
    localparam logic [AW-1:0] WPHI  = 5'h0F;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic          ceb;
    logic          rnw;
    logic          oeb;
    logic          wp_en;
    logic          tb_drive;
    logic [DW-1:0] tb_wdata;
    wire  [DW-1:0] data;
    logic          busy;
    logic          watch_hit;
    logic [3:0]    err;
    logic [31:0]   rd_count;
    logic [31:0]   wr_count;

    assign data = tb_drive ? tb_wdata : {DW{1'bz}};

    always #5 clk = ~clk;

    sram_model_p #(
        .DW             (DW),
        .AW             (AW),
        .DEPTH          (DEPTH),
        .TACC           (TACC),
        .TWP            (TWP),
        .CLEAR_ON_RESET (1'b1),
        .WATCH_ADDR     (WATCH),
        .WP_LO          (WPLO),
        .WP_HI          (WPHI)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .data      (data),
        .ceb       (ceb),
        .rnw       (rnw),
        .oeb       (oeb),
        .wp_en     (wp_en),
        .busy      (busy),
        .watch_hit (watch_hit),
        .err       (err),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    // Reference state
    logic [DW-1:0] m_mem [DEPTH];
    logic [31:0]   m_wr;
    logic [31:0]   m_rd;
    logic [3:0]    m_err;
    logic          m_watch;
    logic [DW-1:0] sb_q [$];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Used while read data must not yet be the stored value
    task automatic check_not(input string tag, input logic [31:0] obs, input logic [31:0] bad);
        n_vec++;
        assert (obs !== bad) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected anything but %0h", tag, obs, bad);
        end
    endtask

    task automatic model_reset();
        m_wr    = '0;
        m_rd    = '0;
        m_err   = '0;
        m_watch = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endtask

    // Entered and left on a falling edge
    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input int len);
        addr     = a;
        tb_wdata = d;
        tb_drive = 1'b1;
        ceb      = 1'b0;
        rnw      = 1'b0;
        repeat (len) @(negedge clk);
        ceb = 1'b1;
        rnw = 1'b1;
        @(negedge clk);
        tb_drive = 1'b0;
        if (len < TWP) m_err[0] = 1'b1;
        if (a >= DEPTH) begin
            m_err[3] = 1'b1;
        end else if (len >= TWP && !(wp_en && a >= WPLO && a <= WPHI)) begin
            m_mem[a] = d;
            m_wr++;
            if (a == WATCH) m_watch = 1'b1;
        end
    endtask

    task automatic read_word(input logic [AW-1:0] a, input bit chk_latency, input string tag);
        logic [DW-1:0] exp_v;
        sb_q.push_back(m_mem[a]);
        addr = a;
        rnw  = 1'b1;
        ceb  = 1'b0;
        oeb  = 1'b0;
        for (int i = 0; i < TACC; i++) begin
            @(negedge clk);
            if (chk_latency) check_not({tag, "_early"}, {24'h0, data}, {24'h0, m_mem[a]});
        end
        @(negedge clk);
        exp_v = sb_q.pop_front();
        check(tag, {24'h0, data}, {24'h0, exp_v});
        ceb = 1'b1;
        oeb = 1'b1;
        @(negedge clk);
        m_rd++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles;

        rst      = 1'b1;
        addr     = '0;
        ceb      = 1'b1;
        rnw      = 1'b1;
        oeb      = 1'b1;
        wp_en    = 1'b0;
        tb_drive = 1'b0;
        tb_wdata = '0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy",  {31'h0, busy},      32'h1);
        check("rst_err",   {28'h0, err},       32'h0);
        check("rst_watch", {31'h0, watch_hit}, 32'h0);
        check("rst_rdcnt", rd_count,           32'h0);
        check("rst_wrcnt", wr_count,           32'h0);

        // Clear walk lasts exactly DEPTH clocks
        rst = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            busy_cycles++;
            @(negedge clk);
        end
        check("busy_cycles", busy_cycles, DEPTH);
        check("busy_done", {31'h0, busy}, 32'h0);

        // Full-width write then read with access-time latency
        write_word(5'h03, 8'hA5, 3);
        read_word(5'h03, 1'b1, "rd_3");
        check("wrcnt_1", wr_count, m_wr);
        check("rdcnt_1", rd_count, m_rd);
        read_word(5'h05, 1'b0, "rd_5_cleared");
        check("rdcnt_2", rd_count, m_rd);

        // Short write strobe
        write_word(5'h04, 8'h77, 1);
        check("short_err", {28'h0, err}, {28'h0, m_err});
        check("short_wrcnt", wr_count, m_wr);
        read_word(5'h04, 1'b0, "rd_4_unchanged");

        // Address moves during the write strobe
        addr     = 5'h06;
        tb_wdata = 8'h99;
        tb_drive = 1'b1;
        ceb      = 1'b0;
        rnw      = 1'b0;
        @(negedge clk);
        addr = 5'h07;
        repeat (2) @(negedge clk);
        ceb = 1'b1;
        rnw = 1'b1;
        @(negedge clk);
        tb_drive = 1'b0;
        m_err[1] = 1'b1;
        check("addrchg_err", {28'h0, err}, {28'h0, m_err});
        check("addrchg_wrcnt", wr_count, m_wr);
        read_word(5'h06, 1'b0, "rd_6");
        read_word(5'h07, 1'b0, "rd_7");

        // Write-protect window
        wp_en = 1'b1;
        write_word(5'h0A, 8'h55, 3);
        check("wp_wrcnt", wr_count, m_wr);
        read_word(5'h0A, 1'b0, "rd_a_protected");
        wp_en = 1'b0;
        write_word(5'h0A, 8'h55, 3);
        check("nowp_wrcnt", wr_count, m_wr);
        read_word(5'h0A, 1'b0, "rd_a_written");

        // Watch address trap
        check("watch_before", {31'h0, watch_hit}, 32'h0);
        write_word(WATCH, 8'h3C, 2);
        check("watch_set", {31'h0, watch_hit}, {31'h0, m_watch});
        repeat (3) @(negedge clk);
        check("watch_sticky", {31'h0, watch_hit}, {31'h0, m_watch});
        read_word(WATCH, 1'b0, "rd_watch");

        // Out-of-range write
        write_word(5'h13, 8'hEE, 2);
        check("oor_err", {28'h0, err}, {28'h0, m_err});
        check("oor_wrcnt", wr_count, m_wr);
        check("rdcnt_end", rd_count, m_rd);

        // Second reset: sticky state clears, access during clear flagged
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        check("rst2_err",   {28'h0, err},       32'h0);
        check("rst2_watch", {31'h0, watch_hit}, 32'h0);
        check("rst2_wrcnt", wr_count,           32'h0);
        rst = 1'b0;
        ceb = 1'b0;
        @(negedge clk);
        ceb = 1'b1;
        m_err[2] = 1'b1;
        check("busy_err", {28'h0, err}, {28'h0, m_err});
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        check("busy_done2", {31'h0, busy}, 32'h0);
        read_word(5'h03, 1'b0, "rd_3_recleared");
        check("rdcnt_after", rd_count, m_rd);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
